neuron_lif_core: RTL and testbench
==================================

Name: neuron_lif_core

Overview:
- Leaky integrate-and-fire neuron; the compute stage directly downstream of the IO handshake frontend.
- Consumes one synchronized command byte per input handshake (in_fire + in_data).
- Drives have_out/out_data back to the frontend and holds each result until the output handshake (out_fire) completes.
- While have_out is high the frontend refuses new input.

Parameters:
- V_WIDTH, 12, signed membrane width in bits (minimum 9).
- THRESH_DEFAULT, 64, threshold after reset.
- LEAK_DEFAULT, 3, leak shift after reset (0..7).
- LEAK_TICK_LOG2, 8, autoleak period is 2^N cycles (used only with NEURON_AUTOLEAK_EN).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- ena  in  1  block enable; when low, in_fire is ignored and all state is frozen.
- in_fire  in  1  input handshake completes this cycle.
- in_data  in  8  synchronized command byte, valid when in_fire is high.
- out_fire  in  1  output handshake completes this cycle.
- have_out  out  1  result pending; the frontend uses it as out_req.
- out_data  out  8  result byte, stable while have_out is high.
- spike  out  1  one-cycle pulse on each fire event.
- drop_err  out  1  sticky flag: a command arrived while a result was pending.

Behaviour:
- Interface: one clock (clk). Reset rst is asynchronous and active-high.
- Reset values:
  - Outputs: have_out=0, out_data=0x00, spike=0, drop_err=0.
  - Internal state: v=0, thresh=THRESH_DEFAULT, leak=LEAK_DEFAULT, refr_reload=0, refr_cnt=0, spike_cnt=0, state=IDLE.
- Reset asserted mid-handshake drops the pending result immediately (have_out=0).
- FSM states: IDLE and OUT_HOLD.
  - IDLE & ena & in_fire: execute the command in that cycle; all register updates land at the next edge.
  - If the command produces a result: go to OUT_HOLD with have_out=1 one cycle after in_fire.
  - OUT_HOLD & out_fire: go to IDLE with have_out=0 at the next edge. out_fire in IDLE is ignored.
- Opcode in_data[7:6]:
  - 00 STIM: v <= sat(v + sext(in_data[5:0])). Ignored while refr_cnt != 0. No result.
  - 01 THRESH: thresh <= {in_data[5:0], 2'b00} (range 0..252). No result.
  - 10 CFG: leak <= in_data[2:0]; refr_reload <= in_data[5:3]. No result.
  - 11 STEP, evaluated in this order:
    - If refr_cnt != 0: refr_cnt <= refr_cnt - 1; v <= 0; no spike.
    - Else compute vl = v - (v >>> leak) (arithmetic shift; leak=0 means no leak).
    - If vl >= thresh (signed compare): fire. v <= 0; refr_cnt <= refr_reload; spike_cnt <= spike_cnt + 1 (7-bit, wraps 127->0); spike=1 for one cycle; result out_data = {1, new spike_cnt}.
    - Else: v <= vl. If in_data[0]=1 (report), result out_data = {0, clamp(vl, 0..127)}; otherwise no result.
- Arithmetic: sat() clamps to [-2^(V_WIDTH-1), 2^(V_WIDTH-1)-1]; no wrap-around allowed.
- in_fire while in OUT_HOLD:
  - The command is discarded and drop_err <= 1, held until reset.
  - out_fire in the same cycle is still honoured.
- ena low:
  - in_fire is ignored and drop_err is not set.
  - The FSM, v and counters hold; have_out and out_data hold.
  - out_fire is still honoured, so a pending result can drain.

Optional Feature:
- Macro: NEURON_AUTOLEAK_EN.
- Defined:
  - A free-running LEAK_TICK_LOG2-bit counter runs while ena=1; reset value 0.
  - On wrap, if state=IDLE and in_fire=0: v <= v - (v >>> leak), with no threshold compare and no result.
  - A tick that coincides with in_fire or with OUT_HOLD is skipped, not deferred.
- Undefined: no counter; leak is applied only by STEP.

Test Plan:
- Reset -> have_out=0, out_data=0x00, drop_err=0; STEP+report (0xC1) -> out_data=0x00 one cycle after in_fire.
- Defaults: STIM 0x1F twice (v=62); STEP 0xC0 -> no result, v=55; STEP 0xC1 -> out_data=0x31 (49), have_out held until out_fire, then 0 next cycle.
- CFG 0x80 (leak 0); STIM 0x1F, 0x1F, 0x02 (v=64); STEP 0xC0 -> spike pulse, out_data=0x81, v=0.
- CFG 0x90 (refr 2); force a spike; STIM x3 -> ignored; STEP, STEP -> no spike; STIM 0x1F, 0x1F, 0x02; STEP -> out_data=0x82.
- STIM 0x20 (-32) x70 -> v saturates at -2048; STIM 0x1F -> v=-2017 (no wrap); STEP 0xC1 -> out_data=0x00.
- While in OUT_HOLD, pulse in_fire (STIM 0x1F) together with out_fire -> result drained, v unchanged, drop_err=1 and stays 1 until rst.

Source files
------------

// File: rtl/neuron_lif_core.sv
// Leaky integrate-and-fire neuron that executes one command byte per input handshake.
// Optional NEURON_AUTOLEAK_EN adds a periodic leak tick every 2^LEAK_TICK_LOG2 enabled cycles.
module neuron_lif_core #(
   parameter int V_WIDTH        = 12,
   parameter int THRESH_DEFAULT = 64,
   parameter int LEAK_DEFAULT   = 3,
   parameter int LEAK_TICK_LOG2 = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ena,
   input  logic       in_fire,
   input  logic [7:0] in_data,
   input  logic       out_fire,
   output logic       have_out,
   output logic [7:0] out_data,
   output logic       spike,
   output logic       drop_err
);

   localparam logic signed [V_WIDTH-1:0] V_MAX = {1'b0, {(V_WIDTH-1){1'b1}}};
   localparam logic signed [V_WIDTH-1:0] V_MIN = {1'b1, {(V_WIDTH-1){1'b0}}};

   typedef enum logic {IDLE, OUT_HOLD} state_t;

   generate
      if (V_WIDTH < 9 || LEAK_TICK_LOG2 < 1) begin : g_bad_param
         $error("neuron_lif_core: V_WIDTH must be >= 9 and LEAK_TICK_LOG2 >= 1");
      end
   endgenerate

   state_t                    r_state;
   logic signed [V_WIDTH-1:0] r_v;
   logic [7:0]                r_thresh;
   logic [2:0]                r_leak;
   logic [2:0]                r_refr_reload;
   logic [2:0]                r_refr_cnt;
   logic [6:0]                r_spike_cnt;
   logic                      r_have_out;
   logic [7:0]                r_out_data;
   logic                      r_spike;
   logic                      r_drop_err;

   logic signed [V_WIDTH:0]   w_sum;
   logic signed [V_WIDTH-1:0] w_stim_v;
   logic signed [V_WIDTH-1:0] w_vl;
   logic signed [V_WIDTH-1:0] w_thresh_ext;
   logic                      w_fire;
   logic [6:0]                w_clamp;
   logic [6:0]                w_cnt_inc;
   logic                      w_tick;

   // One guard bit on the sum: overflow shows up as the top two bits disagreeing.
   assign w_sum        = {r_v[V_WIDTH-1], r_v} + {{(V_WIDTH-5){in_data[5]}}, in_data[5:0]};
   assign w_stim_v     = (w_sum[V_WIDTH] != w_sum[V_WIDTH-1]) ?
                         (w_sum[V_WIDTH] ? V_MIN : V_MAX) : w_sum[V_WIDTH-1:0];
   assign w_vl         = (r_leak == 3'd0) ? r_v : r_v - (r_v >>> r_leak);
   assign w_thresh_ext = $signed({{(V_WIDTH-8){1'b0}}, r_thresh});
   assign w_fire       = (w_vl >= w_thresh_ext);
   assign w_clamp      = w_vl[V_WIDTH-1] ? 7'd0 :
                         (|w_vl[V_WIDTH-2:7]) ? 7'd127 : w_vl[6:0];
   assign w_cnt_inc    = r_spike_cnt + 7'd1;

`ifdef NEURON_AUTOLEAK_EN
   logic [LEAK_TICK_LOG2-1:0] r_tick_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tick_cnt <= '0;
      end else if (ena) begin
         r_tick_cnt <= r_tick_cnt + 1'b1;
      end
   end

   assign w_tick = ena & (&r_tick_cnt);
`else
   assign w_tick = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= IDLE;
         r_v           <= '0;
         r_thresh      <= 8'(THRESH_DEFAULT);
         r_leak        <= 3'(LEAK_DEFAULT);
         r_refr_reload <= 3'd0;
         r_refr_cnt    <= 3'd0;
         r_spike_cnt   <= 7'd0;
         r_have_out    <= 1'b0;
         r_out_data    <= 8'h00;
         r_spike       <= 1'b0;
         r_drop_err    <= 1'b0;
      end else begin
         r_spike <= 1'b0;
         // Draining is allowed even with ena low so a pending result never gets stuck.
         if (r_state == OUT_HOLD && out_fire) begin
            r_state    <= IDLE;
            r_have_out <= 1'b0;
         end
         if (ena) begin
            if (r_state == IDLE && in_fire) begin
               case (in_data[7:6])
                  2'b00: if (r_refr_cnt == 3'd0) r_v <= w_stim_v;
                  2'b01: r_thresh <= {in_data[5:0], 2'b00};
                  2'b10: begin
                     r_leak        <= in_data[2:0];
                     r_refr_reload <= in_data[5:3];
                  end
                  default: begin
                     if (r_refr_cnt != 3'd0) begin
                        r_refr_cnt <= r_refr_cnt - 3'd1;
                        r_v        <= '0;
                     end else if (w_fire) begin
                        r_v         <= '0;
                        r_refr_cnt  <= r_refr_reload;
                        r_spike_cnt <= w_cnt_inc;
                        r_spike     <= 1'b1;
                        r_out_data  <= {1'b1, w_cnt_inc};
                        r_have_out  <= 1'b1;
                        r_state     <= OUT_HOLD;
                     end else begin
                        r_v <= w_vl;
                        if (in_data[0]) begin
                           r_out_data <= {1'b0, w_clamp};
                           r_have_out <= 1'b1;
                           r_state    <= OUT_HOLD;
                        end
                     end
                  end
               endcase
            end else if (r_state == OUT_HOLD && in_fire) begin
               r_drop_err <= 1'b1;
            end else if (r_state == IDLE && w_tick) begin
               r_v <= w_vl;
            end
         end
      end
   end

   assign have_out = r_have_out;
   assign out_data = r_out_data;
   assign spike    = r_spike;
   assign drop_err = r_drop_err;

endmodule

// File: tb/tb_neuron_lif_core.sv
// Scoreboard bench for neuron_lif_core: a behavioural neuron model predicts each result byte.
module tb_neuron_lif_core;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ena = 1'b1;
   logic       in_fire = 1'b0;
   logic [7:0] in_data = 8'h00;
   logic       out_fire = 1'b0;
   logic       have_out;
   logic [7:0] out_data;
   logic       spike;
   logic       drop_err;

   int n_checks = 0;
   int n_errors = 0;

   logic [7:0] q[$];

   int m_v, m_thresh, m_leak, m_reload, m_refr, m_cnt;

   neuron_lif_core dut (
      .clk      (clk),
      .rst      (rst),
      .ena      (ena),
      .in_fire  (in_fire),
      .in_data  (in_data),
      .out_fire (out_fire),
      .have_out (have_out),
      .out_data (out_data),
      .spike    (spike),
      .drop_err (drop_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_v = 0; m_thresh = 64; m_leak = 3; m_reload = 0; m_refr = 0; m_cnt = 0;
   endtask

   task automatic model_exec(input logic [7:0] cmd, output logic sp);
      int s, vl;
      sp = 1'b0;
      case (cmd[7:6])
         2'b00: if (m_refr == 0) begin
            s = m_v + (cmd[5] ? int'(cmd[5:0]) - 64 : int'(cmd[5:0]));
            m_v = (s > 2047) ? 2047 : (s < -2048) ? -2048 : s;
         end
         2'b01: m_thresh = int'(cmd[5:0]) * 4;
         2'b10: begin
            m_leak   = int'(cmd[2:0]);
            m_reload = int'(cmd[5:3]);
         end
         default: begin
            if (m_refr != 0) begin
               m_refr--;
               m_v = 0;
            end else begin
               vl = (m_leak == 0) ? m_v : m_v - (m_v >>> m_leak);
               if (vl >= m_thresh) begin
                  m_v = 0;
                  m_refr = m_reload;
                  m_cnt = (m_cnt + 1) % 128;
                  sp = 1'b1;
                  q.push_back({1'b1, 7'(m_cnt)});
               end else begin
                  m_v = vl;
                  if (cmd[0]) q.push_back({1'b0, 7'((vl < 0) ? 0 : (vl > 127) ? 127 : vl)});
               end
            end
         end
      endcase
   endtask

   task automatic send(input logic [7:0] cmd);
      logic sp;
      model_exec(cmd, sp);
      @(negedge clk);
      in_fire = 1'b1;
      in_data = cmd;
      @(negedge clk);
      in_fire = 1'b0;
      check("spike", spike, sp);
      check("have_out_after_cmd", have_out, q.size() != 0);
      if (sp) begin
         @(negedge clk);
         check("spike_one_cycle", spike, 1'b0);
      end
   endtask

   task automatic drain();
      int waited = 0;
      logic [7:0] exp;
      while (!have_out && waited < 8) begin
         @(negedge clk);
         waited++;
      end
      if (!have_out) begin
         check("drain_timeout", have_out, 1'b1);
         if (q.size() != 0) void'(q.pop_front());
         return;
      end
      check("result_expected", q.size() != 0, 1'b1);
      exp = (q.size() != 0) ? q.pop_front() : 8'h00;
      check("out_data", out_data, exp);
      $display("txn result out_data=0x%02h expected=0x%02h", out_data, exp);
      @(negedge clk);
      check("hold_have_out", have_out, 1'b1);
      check("hold_out_data", out_data, exp);
      out_fire = 1'b1;
      @(negedge clk);
      out_fire = 1'b0;
      check("have_out_clear", have_out, 1'b0);
   endtask

   initial begin
      model_reset();
      repeat (2) @(negedge clk);
      check("rst_have_out", have_out, 1'b0);
      check("rst_out_data", out_data, 8'h00);
      check("rst_spike", spike, 1'b0);
      check("rst_drop_err", drop_err, 1'b0);
      rst = 1'b0;

      // Report on a fresh neuron.
      send(8'hC1); drain();

      // Integrate and leak with default threshold/leak.
      send(8'h1F); send(8'h1F); send(8'hC0); send(8'hC1); drain();

      // No leak, cross the threshold.
      send(8'h80); send(8'h1F); send(8'h1F); send(8'h02); send(8'hC0); drain();

      // Refractory period of 2 steps.
      send(8'h90); send(8'h1F); send(8'h1F); send(8'h02); send(8'hC0); drain();
      send(8'h1F); send(8'h1F); send(8'h1F); send(8'hC1); send(8'hC1);
      send(8'h1F); send(8'h1F); send(8'h02); send(8'hC0); drain();
      send(8'h83); send(8'hC0); send(8'hC0);

      // ena low: command ignored, drain still honoured.
      send(8'h1F);
      @(negedge clk); ena = 1'b0; in_fire = 1'b1; in_data = 8'h1F;
      @(negedge clk); in_fire = 1'b0;
      check("ena_low_no_result", have_out, 1'b0);
      check("ena_low_no_drop", drop_err, 1'b0);
      ena = 1'b1;
      send(8'hC1);
      ena = 1'b0; drain(); ena = 1'b1;

      // Negative then positive saturation.
      for (int i = 0; i < 70; i++) send(8'h20);
      send(8'h1F); send(8'hC1); drain();
      for (int i = 0; i < 70; i++) send(8'h1F);
      send(8'hC1); drain();

      // Command during OUT_HOLD together with out_fire.
      send(8'h1F); send(8'hC1);
      @(negedge clk); in_fire = 1'b1; in_data = 8'h1F; out_fire = 1'b1;
      @(negedge clk); in_fire = 1'b0; out_fire = 1'b0;
      check("drop_drained", have_out, 1'b0);
      check("drop_err_set", drop_err, 1'b1);
      check("drop_out_data", out_data, (q.size() != 0) ? q.pop_front() : 8'hFF);
      send(8'hC1); drain();
      check("drop_err_sticky", drop_err, 1'b1);

      // Reset while a result is pending.
      send(8'hC1);
      @(negedge clk); #2 rst = 1'b1;
      #1;
      check("rst_mid_have_out", have_out, 1'b0);
      check("rst_mid_drop_err", drop_err, 1'b0);
      check("rst_mid_out_data", out_data, 8'h00);
      q.delete();
      model_reset();
      @(negedge clk); rst = 1'b0;
      send(8'hC1); drain();
      send(8'h1F); send(8'h1F); send(8'h1F); send(8'hC0); drain();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
